// File: rtl/imm_gen_pipe.sv
// Pipelined immediate extender: decodes the format (auto or explicit), builds the
// XLEN-wide immediate at input and stages it through a 2-entry skid FIFO.
// Optional macro IMM_SHAMT_TYPE_EN enables the SH (shift amount) format, code 5.
module imm_gen_pipe #(
    parameter int XLEN      = 32,
    parameter bit AUTO_TYPE = 1'b1,
    parameter int TAG_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_imm_type,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_type,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [2:0] T_I   = 3'd0;
    localparam logic [2:0] T_B   = 3'd1;
    localparam logic [2:0] T_S   = 3'd2;
    localparam logic [2:0] T_U   = 3'd3;
    localparam logic [2:0] T_J   = 3'd4;
    localparam logic [2:0] T_SH  = 3'd5;
    localparam logic [2:0] T_BAD = 3'd7;
    localparam int EW = XLEN + 3 + 1 + TAG_W;

    function automatic logic [2:0] decode_type(input logic [31:0] instr);
        logic [2:0] t;
        case (instr[6:0])
            7'b0010011: begin
`ifdef IMM_SHAMT_TYPE_EN
                if ((instr[14:12] == 3'b001) || (instr[14:12] == 3'b101)) begin
                    t = T_SH;
                end else begin
                    t = T_I;
                end
`else
                t = T_I;
`endif
            end
            7'b0000011, 7'b1100111, 7'b1110011: t = T_I;
            7'b0100011:                         t = T_S;
            7'b1100011:                         t = T_B;
            7'b0110111, 7'b0010111:             t = T_U;
            7'b1101111:                         t = T_J;
            default:                            t = T_BAD;
        endcase
        return t;
    endfunction

    function automatic logic type_illegal(input logic [2:0] t);
        logic ill;
        case (t)
            T_I, T_B, T_S, T_U, T_J: ill = 1'b0;
`ifdef IMM_SHAMT_TYPE_EN
            T_SH:                    ill = 1'b0;
`endif
            default:                 ill = 1'b1;
        endcase
        return ill;
    endfunction

    // Every sign-extended format is first built as a signed 32-bit value, then widened.
    function automatic logic [XLEN-1:0] extend_imm(input logic [31:0] instr, input logic [2:0] t);
        logic signed [31:0] v;
        logic [XLEN-1:0]    r;
        v = 32'sd0;
        r = {XLEN{1'b1}};
        case (t)
            T_I: begin
                v = {{20{instr[31]}}, instr[31:20]};
                r = XLEN'(v);
            end
            T_S: begin
                v = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                r = XLEN'(v);
            end
            T_B: begin
                v = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                r = XLEN'(v);
            end
            T_U: begin
                v = {instr[31:12], 12'b0};
                r = XLEN'(v);
            end
            T_J: begin
                v = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                r = XLEN'(v);
            end
`ifdef IMM_SHAMT_TYPE_EN
            T_SH: begin
                if (XLEN == 32) begin
                    r = XLEN'({27'd0, instr[24:20]});
                end else begin
                    r = XLEN'({26'd0, instr[25:20]});
                end
            end
`endif
            default: r = {XLEN{1'b1}};
        endcase
        return r;
    endfunction

    logic [2:0]      res_type_s;
    logic            res_ill_s;
    logic [XLEN-1:0] res_imm_s;
    logic [EW-1:0]   new_s;
    logic [EW-1:0]   head_r;
    logic [EW-1:0]   tail_r;
    logic [1:0]      count_r;
    logic [1:0]      count_nx_s;
    logic            in_ready_r;
    logic            out_valid_r;
    logic            push_s;
    logic            pop_s;

    // Resolve format and build the stored entry from the incoming instruction.
    always_comb begin
        res_type_s = 3'd0;
        if (AUTO_TYPE) begin
            res_type_s = decode_type(in_instr);
        end else begin
            res_type_s = in_imm_type;
        end
        res_ill_s = type_illegal(res_type_s);
        res_imm_s = extend_imm(in_instr, res_type_s);
        new_s     = {res_imm_s, res_type_s, res_ill_s, in_tag};
    end

    assign push_s = in_valid & in_ready_r;
    assign pop_s  = out_valid_r & out_ready;

    // Next occupancy; pop is only possible when non-empty, push only when not full.
    always_comb begin
        count_nx_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nx_s = count_r + 2'd1;
            2'b01:   count_nx_s = count_r - 2'd1;
            default: count_nx_s = count_r;
        endcase
    end

    // FIFO storage: head feeds the outputs directly, tail holds the skid entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r     <= 2'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            head_r      <= {EW{1'b0}};
            tail_r      <= {EW{1'b0}};
        end else begin
            count_r     <= count_nx_s;
            in_ready_r  <= (count_nx_s < 2'd2);
            out_valid_r <= (count_nx_s != 2'd0);
            if (push_s && ((count_r == 2'd0) || (pop_s && (count_r == 2'd1)))) begin
                head_r <= new_s;
            end else if (pop_s && (count_r == 2'd2)) begin
                head_r <= tail_r;
            end
            if (push_s && !pop_s && (count_r == 2'd1)) begin
                tail_r <= new_s;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign {out_imm, out_type, out_illegal, out_tag} = head_r;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: vector table, FIFO corner sequences and
// randomized traffic scored against a queue-based reference model.
module tb_imm_gen_pipe;

`ifdef IMM_SHAMT_TYPE_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // auto-mode, XLEN=32 instance
    logic a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_illegal;
    logic [31:0] a_instr, a_out_imm;
    logic [2:0]  a_imm_type, a_out_type;
    logic [4:0]  a_tag, a_out_tag;
    // manual-mode instance
    logic m_in_valid, m_in_ready, m_out_valid, m_out_ready, m_out_illegal;
    logic [31:0] m_instr, m_out_imm;
    logic [2:0]  m_imm_type, m_out_type;
    logic [4:0]  m_tag, m_out_tag;
    // auto-mode, XLEN=64 instance
    logic w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_out_illegal;
    logic [31:0] w_instr;
    logic [63:0] w_out_imm;
    logic [2:0]  w_imm_type, w_out_type;
    logic [4:0]  w_tag, w_out_tag;

    imm_gen_pipe #(.XLEN(32), .AUTO_TYPE(1'b1), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_instr(a_instr), .in_imm_type(a_imm_type), .in_tag(a_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_imm(a_out_imm),
        .out_type(a_out_type), .out_illegal(a_out_illegal), .out_tag(a_out_tag));

    imm_gen_pipe #(.XLEN(32), .AUTO_TYPE(1'b0), .TAG_W(5)) dut_m (
        .clk(clk), .rst(rst), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .in_instr(m_instr), .in_imm_type(m_imm_type), .in_tag(m_tag),
        .out_valid(m_out_valid), .out_ready(m_out_ready), .out_imm(m_out_imm),
        .out_type(m_out_type), .out_illegal(m_out_illegal), .out_tag(m_out_tag));

    imm_gen_pipe #(.XLEN(64), .AUTO_TYPE(1'b1), .TAG_W(5)) dut64 (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_instr(w_instr), .in_imm_type(w_imm_type), .in_tag(w_tag),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_imm(w_out_imm),
        .out_type(w_out_type), .out_illegal(w_out_illegal), .out_tag(w_out_tag));

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [2:0]  typ;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [31:0] imm;
        logic [2:0]  typ;
        logic        ill;
        logic [4:0]  tag;
    } exp_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---- reference model: formats computed by integer field arithmetic ----
    function automatic longint sx(input longint v, input int bits);
        longint one;
        one = 64'sd1;
        if (v[bits-1]) return v - (one << bits);
        else return v;
    endfunction

    function automatic logic [2:0] ref_type(input logic [31:0] instr);
        int op, f3;
        op = int'(instr & 32'h7F);
        f3 = int'((instr >> 12) & 32'h7);
        case (op)
            'h13:               return (FEAT && (f3 == 1 || f3 == 5)) ? 3'd5 : 3'd0;
            'h03, 'h67, 'h73:   return 3'd0;
            'h23:               return 3'd2;
            'h63:               return 3'd1;
            'h37, 'h17:         return 3'd3;
            'h6F:               return 3'd4;
            default:            return 3'd7;
        endcase
    endfunction

    function automatic logic ref_ill(input logic [2:0] t);
        return (t > 3'd5) || (t == 3'd5 && !FEAT);
    endfunction

    function automatic logic [63:0] ref_imm(input logic [31:0] instr, input logic [2:0] t, input int xlen);
        longint li, v;
        logic [63:0] mask;
        li = longint'(instr);
        mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        if (ref_ill(t)) return mask;
        case (t)
            3'd0: v = sx(li >> 20, 12);
            3'd2: v = sx(((li >> 25) << 5) | ((li >> 7) & 31), 12);
            3'd1: v = sx((((li >> 31) & 1) << 12) | (((li >> 7) & 1) << 11)
                         | (((li >> 25) & 63) << 5) | (((li >> 8) & 15) << 1), 13);
            3'd3: v = sx(li & 64'hFFFF_F000, 32);
            3'd4: v = sx((((li >> 31) & 1) << 20) | (((li >> 12) & 255) << 12)
                         | (((li >> 20) & 1) << 11) | (((li >> 21) & 1023) << 1), 21);
            default: v = (xlen == 64) ? ((li >> 20) & 63) : ((li >> 20) & 31);
        endcase
        return 64'(v) & mask;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  ops [11];
        ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};
        r = $urandom;
        r[6:0] = ops[$urandom_range(0, 10)];
        return r;
    endfunction

    task automatic run_manual(input logic [31:0] instr, input logic [2:0] t,
                              input logic [31:0] eimm, input logic [2:0] et, input logic eill);
        @(negedge clk);
        m_in_valid = 1'b1; m_instr = instr; m_imm_type = t; m_tag = 5'd9;
        @(posedge clk);
        @(negedge clk);
        m_in_valid = 1'b0;
        chk("man_valid", 64'(m_out_valid), 64'd1);
        chk("man_imm", 64'(m_out_imm), 64'(eimm));
        chk("man_type", 64'(m_out_type), 64'(et));
        chk("man_ill", 64'(m_out_illegal), 64'(eill));
    endtask

    task automatic run_w64(input logic [31:0] instr, input logic [63:0] eimm, input logic [2:0] et);
        @(negedge clk);
        w_in_valid = 1'b1; w_instr = instr; w_tag = 5'd4;
        @(posedge clk);
        @(negedge clk);
        w_in_valid = 1'b0;
        chk("x64_valid", 64'(w_out_valid), 64'd1);
        chk("x64_imm", w_out_imm, eimm);
        chk("x64_type", 64'(w_out_type), 64'(et));
    endtask

    vec_t vecs [10];
    exp_t q [$];
    int   got [$];

    initial begin
        a_in_valid = 1'b0; a_instr = 32'd0; a_imm_type = 3'd0; a_tag = 5'd0; a_out_ready = 1'b1;
        m_in_valid = 1'b0; m_instr = 32'd0; m_imm_type = 3'd0; m_tag = 5'd0; m_out_ready = 1'b1;
        w_in_valid = 1'b0; w_instr = 32'd0; w_imm_type = 3'd0; w_tag = 5'd0; w_out_ready = 1'b1;

        vecs[0] = '{32'hFFF00093, 32'hFFFFFFFF, 3'd0, 1'b0};
        vecs[1] = '{32'h00112623, 32'h0000000C, 3'd2, 1'b0};
        vecs[2] = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd1, 1'b0};
        vecs[3] = '{32'h0080006F, 32'h00000008, 3'd4, 1'b0};
        vecs[4] = '{32'h123450B7, 32'h12345000, 3'd3, 1'b0};
        vecs[5] = '{32'h00000033, 32'hFFFFFFFF, 3'd7, 1'b1};
        vecs[6] = '{32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0};
        vecs[7] = '{32'h80000017, 32'h80000000, 3'd3, 1'b0};
        vecs[8] = '{32'h00000013, 32'h00000000, 3'd0, 1'b0};
        if (FEAT) vecs[9] = '{32'h03F09093, 32'h0000001F, 3'd5, 1'b0};
        else      vecs[9] = '{32'h03F09093, 32'h0000003F, 3'd0, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_in_ready", 64'(a_in_ready), 64'd1);
        chk("rst_imm", 64'(a_out_imm), 64'd0);
        chk("rst_tag", 64'(a_out_tag), 64'd0);

        // Table: one instruction per cycle, each visible one edge after acceptance.
        for (int i = 0; i < 10; i++) begin
            a_in_valid = 1'b1; a_instr = vecs[i].instr; a_tag = 5'(i);
            @(posedge clk);
            @(negedge clk);
            a_in_valid = 1'b0;
            chk("tbl_valid", 64'(a_out_valid), 64'd1);
            chk("tbl_imm", 64'(a_out_imm), 64'(vecs[i].imm));
            chk("tbl_type", 64'(a_out_type), 64'(vecs[i].typ));
            chk("tbl_ill", 64'(a_out_illegal), 64'(vecs[i].ill));
            chk("tbl_tag", 64'(a_out_tag), 64'(i));
        end
        @(posedge clk);
        @(negedge clk);
        chk("tbl_drained", 64'(a_out_valid), 64'd0);

        // Backpressure: three offers with the consumer stalled.
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_instr = 32'h00100093; a_tag = 5'd1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_ready_after1", 64'(a_in_ready), 64'd1);
        a_instr = 32'h00200093; a_tag = 5'd2;
        @(posedge clk);
        @(negedge clk);
        chk("bp_ready_low", 64'(a_in_ready), 64'd0);
        a_instr = 32'h00300093; a_tag = 5'd3;
        @(posedge clk);
        @(negedge clk);
        chk("bp_still_full", 64'(a_in_ready), 64'd0);
        chk("bp_head_stable", 64'(a_out_tag), 64'd1);
        chk("bp_head_imm", 64'(a_out_imm), 64'd1);
        a_out_ready = 1'b1;
        got.delete();
        for (int c = 0; c < 12 && got.size() < 3; c++) begin
            logic acc;
            if (a_out_valid) got.push_back(int'(a_out_tag));
            acc = a_in_valid && a_in_ready;
            @(posedge clk);
            @(negedge clk);
            if (acc) a_in_valid = 1'b0;
        end
        a_in_valid = 1'b0;
        chk("bp_count", 64'(got.size()), 64'd3);
        for (int k = 0; k < got.size(); k++) chk("bp_order", 64'(got[k]), 64'(k + 1));
        @(posedge clk);
        @(negedge clk);
        chk("bp_empty", 64'(a_out_valid), 64'd0);

        // Reset while two entries are buffered.
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_instr = 32'hFFF00093; a_tag = 5'd7;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("full_before_rst", 64'(a_in_ready), 64'd0);
        a_in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_valid", 64'(a_out_valid), 64'd0);
        chk("mrst_ready", 64'(a_in_ready), 64'd1);
        chk("mrst_imm", 64'(a_out_imm), 64'd0);
        chk("mrst_type", 64'(a_out_type), 64'd0);
        chk("mrst_ill", 64'(a_out_illegal), 64'd0);
        chk("mrst_tag", 64'(a_out_tag), 64'd0);

        // Manual mode and XLEN=64 instances.
        run_manual(32'h00000033, 3'd6, 32'hFFFFFFFF, 3'd6, 1'b1);
        run_manual(32'hFFF00093, 3'd0, 32'hFFFFFFFF, 3'd0, 1'b0);
        run_manual(32'h123450B7, 3'd3, 32'h12345000, 3'd3, 1'b0);
        run_manual(32'h03F09093, 3'd5, FEAT ? 32'h0000001F : 32'hFFFFFFFF, 3'd5, !FEAT);
        run_manual(32'h0080006F, 3'd7, 32'hFFFFFFFF, 3'd7, 1'b1);
        run_w64(32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0);
        run_w64(32'h03F09093, 64'h0000_0000_0000_003F, FEAT ? 3'd5 : 3'd0);
        run_w64(32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3'd3);

        // Randomized traffic against the queue model.
        q.delete();
        a_in_valid = 1'b0; a_out_ready = 1'b0;
        for (int c = 0; c < 600; c++) begin
            exp_t e;
            bit push, pop;
            if (q.size() > 0) begin
                chk("rnd_valid", 64'(a_out_valid), 64'd1);
                chk("rnd_imm", 64'(a_out_imm), 64'(q[0].imm));
                chk("rnd_type", 64'(a_out_type), 64'(q[0].typ));
                chk("rnd_ill", 64'(a_out_illegal), 64'(q[0].ill));
                chk("rnd_tag", 64'(a_out_tag), 64'(q[0].tag));
            end else begin
                chk("rnd_empty", 64'(a_out_valid), 64'd0);
            end
            chk("rnd_ready", 64'(a_in_ready), 64'(q.size() < 2));
            a_in_valid  = ($urandom_range(0, 3) != 0);
            a_out_ready = ($urandom_range(0, 3) != 0);
            a_instr     = rand_instr();
            a_tag       = 5'($urandom);
            e.typ = ref_type(a_instr);
            e.ill = ref_ill(e.typ);
            e.imm = 32'(ref_imm(a_instr, e.typ, 32));
            e.tag = a_tag;
            push = a_in_valid && (q.size() < 2);
            pop  = a_out_ready && (q.size() > 0);
            if (pop) void'(q.pop_front());
            if (push) q.push_back(e);
            @(posedge clk);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined successor to the combinational immediate extender. It accepts full 32-bit instructions over a valid/ready handshake and either derives the immediate format from the opcode (auto mode) or takes it from an explicit type input. It produces an XLEN-wide sign-extended immediate through a 2-entry skid buffer. It sits between fetch/decode and the execute operand mux.

Parameters:
XLEN, 32, immediate output width; legal values 32 or 64.
AUTO_TYPE, 1, 1 = format decoded from opcode; 0 = format taken from in_imm_type.
TAG_W, 5, width of the sideband tag carried alongside each instruction (e.g. rd or ROB index).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous reset, active high.
in_valid  in  1  instruction present.
in_ready  out  1  buffer can accept; registered.
in_instr  in  32  full instruction word, opcode included.
in_imm_type  in  3  format code: 0=I, 1=B, 2=S, 3=U, 4=J, 5=SH; ignored when AUTO_TYPE=1.
in_tag  in  TAG_W  sideband tag.
out_valid  out  1  head entry valid.
out_ready  in  1  consumer accepts head.
out_imm  out  XLEN  extended immediate.
out_type  out  3  resolved format code.
out_illegal  out  1  format unknown or unsupported.
out_tag  out  TAG_W  tag of head entry.

Behaviour:
- One clock domain (clk), synchronous active-high reset (rst).
- Reset: count=0, in_ready=1, out_valid=0, out_imm=0, out_type=0, out_illegal=0, out_tag=0. Reset mid-transfer drops both entries; no partial output appears.
- Storage: 2-entry FIFO of {imm, type, illegal, tag}. The immediate is computed combinationally at input and stored already extended.
- Push when in_valid && in_ready. Pop when out_valid && out_ready.
- in_ready = (count<2), registered from next-state count.
- out_valid = (count>0). The head is driven from a register, never combinationally from in_instr.
- Latency: accepted at edge N, visible at out_* after edge N when the buffer was empty. No bypass. Throughput is 1 per cycle while out_ready=1.
- Simultaneous push+pop with count=1 keeps count=1; the new entry becomes head on the next edge. With count=2, no push is possible (in_ready=0). A pop with count=0 is ignored.
- Order is strictly FIFO. Head outputs stay stable while out_valid && !out_ready.
- Formats (sext = sign-extend to XLEN from instr[31]):
  - I: sext(instr[31:20])
  - S: sext({instr[31:25],instr[11:7]})
  - B: sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0})
  - U: sext({instr[31:12],12'b0})
  - J: sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0})
- Auto decode on instr[6:0]:
  - 0010011, 0000011, 1100111, 1110011 → I
  - 0100011 → S
  - 1100011 → B
  - 0110111, 0010111 → U
  - 1101111 → J
  - anything else → illegal
- Illegal or unknown type code (manual mode: codes 5 without the optional feature, 6, 7): out_imm = all ones, out_illegal=1, out_type = the code as given. In auto mode, illegal opcodes report out_type=7.

Optional Feature:
IMM_SHAMT_TYPE_EN
- Defined: type 5 (SH) is supported.
  - out_imm = zero-extended shift amount: instr[24:20] when XLEN=32, instr[25:20] when XLEN=64.
  - In auto mode, opcode 0010011 with funct3 001 or 101 resolves to SH instead of I.
- Undefined: type 5 is illegal (all ones, out_illegal=1), and auto mode always resolves 0010011 to I.

Test Plan:
- Auto, XLEN=32: 0xFFF00093 → out_imm=0xFFFFFFFF, type 0. Then 0x00112623 → 0x0000000C, type 2. One-cycle latency each with out_ready=1.
- Branch/jump/upper: 0xFE000EE3 → 0xFFFFFFFC type 1; 0x0080006F → 0x00000008 type 4; 0x123450B7 → 0x12345000 type 3.
- Backpressure: out_ready=0, offer 3 instructions back-to-back → in_ready falls after the 2nd accept, 3rd held. Raise out_ready → 3 outputs in order, tags 1,2,3, none lost or duplicated.
- Illegal: 0x00000033 in auto mode → out_illegal=1, out_imm=0xFFFFFFFF, out_type=7. Manual mode with in_imm_type=6 → same imm, out_type=6.
- XLEN=64: 0xFFF00093 → 0xFFFFFFFFFFFFFFFF. With IMM_SHAMT_TYPE_EN, 0x03F09093 (slli x1,x1,63) → 0x000000000000003F, type 5.
- Reset with 2 entries buffered → next cycle out_valid=0, in_ready=1, all outputs zero.
